fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Owns the PC and issues requests to an instruction memory with a variable-latency request/response handshake.
- Buffers returned instructions in a small queue and presents one instruction per cycle (Instruction, PC_plus2, Valid_PC) to decode.
- Honours stall, redirect (branch/jump/exception) and halt.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_queue.sv | 51 +++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants and the fetch state encoding.
package fetch_stage_pkg;

    localparam logic [15:0] Nop    = 16'h0800;
    localparam logic [4:0]  OpHalt = 5'b00000;
    localparam logic [4:0]  OpLd   = 5'b10001;

    typedef enum logic [0:0] {
        StRun,
        StHalted
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {instruction, fetch address} pairs.
module fetch_queue #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to imem, and feeds decode one word per cycle.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Redirect_valid,
    input  logic [15:0] Redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] Instruction,
    output logic [15:0] PC_plus2,
    output logic        Valid_PC,
    output logic        err
);

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q;
    logic [15:0]     pc_q, resp_pc_q, instr_q, pc_plus2_q;
    logic            valid_q, err_q;
    logic [CntW-1:0] outstanding_q, discard_q, q_count;
    logic [CntW:0]   inflight;
    logic            accept, resp_drop, q_push, q_pop, q_full, q_empty, out_load;
    logic [31:0]     q_rdata;
    logic [15:0]     redirect_target;

    always_comb begin
        inflight        = {1'b0, outstanding_q} + {1'b0, q_count};
        imem_req        = rst && (state_q == StRun) && !Halt && !Redirect_valid &&
                          (inflight < (CntW + 1)'(QDEPTH));
        accept          = imem_req && imem_ready;
        resp_drop       = imem_rvalid && (discard_q != '0);
        q_push          = imem_rvalid && !resp_drop && !Redirect_valid;
        out_load        = !Stall || !valid_q;
        q_pop           = out_load && !q_empty && !Redirect_valid;
        redirect_target = {Redirect_pc[15:1], 1'b0};
    end

    // resp_pc_q tracks the address of the next response that will be kept,
    // so the queue needs no per-request address bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            instr_q       <= Nop;
            pc_plus2_q    <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + CntW'(accept) - CntW'(imem_rvalid);
            if (Redirect_valid) begin
                pc_q      <= redirect_target;
                resp_pc_q <= redirect_target;
                discard_q <= outstanding_q - CntW'(imem_rvalid);
                instr_q   <= Nop;
                valid_q   <= 1'b0;
                if (Redirect_pc[0]) err_q <= 1'b1;
            end else begin
                if (accept)    pc_q      <= pc_q + 16'd2;
                if (resp_drop) discard_q <= discard_q - CntW'(1);
                if (q_push)    resp_pc_q <= resp_pc_q + 16'd2;
                if (out_load) begin
                    if (!q_empty) begin
                        instr_q    <= q_rdata[31:16];
                        pc_plus2_q <= q_rdata[15:0] + 16'd2;
                        valid_q    <= 1'b1;
                    end else begin
                        instr_q <= Nop;
                        valid_q <= 1'b0;
                    end
                end
                if (state_q == StRun && Halt) state_q <= StHalted;
            end
        end
    end

    fetch_queue #(
        .Depth (QDEPTH),
        .Width (32)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (q_push),
        .data_i  ({imem_rdata, resp_pc_q}),
        .pop_i   (q_pop),
        .flush_i (Redirect_valid),
        .data_o  (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PC_plus2    = pc_plus2_q;
    assign Valid_PC    = valid_q;
    assign err         = err_q;

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order imem model plus a scoreboard of expected fetched words.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Stall = 1'b0, Halt = 1'b0, Redirect_valid = 1'b0;
    logic [15:0] Redirect_pc = '0;
    logic        imem_req, imem_ready = 1'b1, imem_rvalid = 1'b0;
    logic [15:0] imem_addr, imem_rdata = '0;
    logic [15:0] Instruction, PC_plus2;
    logic        Valid_PC, err;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .Halt           (Halt),
        .Redirect_valid (Redirect_valid),
        .Redirect_pc    (Redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .PC_plus2       (PC_plus2),
        .Valid_PC       (Valid_PC),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } exp_t;

    typedef struct {
        logic [15:0] target;
        int          lat;
        logic        stall;
        logic        exp_err;
        logic [15:0] first;
    } row_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    row_t        rows[5];
    int          total = 0, bad = 0, cyc = 0, lat = 1;
    bit          rand_ready = 0, halted = 0;
    logic        req_s;
    logic [15:0] addr_s;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return {a[3:0], a[15:4]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock: sample request/response before the edge, model memory and
    // scoreboard after it, then drive the next memory response.
    task automatic cycle();
        logic        redir, rv, acc, ld_en, pv;
        logic [15:0] pi, pp;
        exp_t        e;
        #1;
        req_s  = imem_req;
        addr_s = imem_addr;
        redir  = Redirect_valid;
        rv     = imem_rvalid;
        acc    = imem_req && imem_ready;
        ld_en  = !Stall || !Valid_PC;
        pi     = Instruction;
        pp     = PC_plus2;
        pv     = Valid_PC;
        if (halted) chk("halt_no_req", imem_req, 0);
        if (redir)  chk("redir_no_req", imem_req, 0);
        @(posedge clk);
        cyc++;
        #1;
        if (rv && pend.size() > 0) void'(pend.pop_front());
        if (redir) exp_q.delete();
        if (redir) begin
            chk("redir_valid_clr", Valid_PC, 0);
        end else if (!ld_en) begin
            chk("stall_hold_instr", Instruction, pi);
            chk("stall_hold_pcp2", PC_plus2, pp);
            chk("stall_hold_valid", Valid_PC, pv);
        end else if (Valid_PC) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h@%h want none", Instruction, PC_plus2);
            end else begin
                e = exp_q.pop_front();
                chk("instr", Instruction, e.instr);
                chk("pc_plus2", PC_plus2, e.pcp2);
            end
        end else begin
            chk("nop_when_empty", Instruction, 16'h0800);
        end
        if (acc) begin
            pend.push_back('{addr: addr_s, due: cyc - 1 + lat});
            exp_q.push_back('{instr: memw(addr_s), pcp2: addr_s + 16'd2});
        end
        chk("inflight_cap", exp_q.size() <= 2, 1);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'hDEAD;
        end
        imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic first_req(input logic [15:0] want);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (req_s) begin
                got = 1;
                chk("first_req_addr", addr_s, want);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL first_req_timeout: got none want %h", want);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_instr", Instruction, 16'h0800);
        chk("rst_pcp2", PC_plus2, 16'h0000);
        chk("rst_valid", Valid_PC, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_err", err, 0);
    endtask

    // Asserts reset mid-cycle, optionally with a response pulse in flight.
    task automatic reset_dut(input bit pulse);
        #2;
        if (pulse) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hBAD0;
        end
        rst = 1'b0;
        #1;
        check_reset_vals();
        imem_rvalid = 1'b0;
        pend.delete();
        exp_q.delete();
        Halt   = 1'b0;
        halted = 0;
        Stall  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        bit found;
        rows[0] = '{16'h0040, 3, 1'b0, 1'b0, 16'h0040};
        rows[1] = '{16'h0080, 2, 1'b1, 1'b0, 16'h0080};
        rows[2] = '{16'hFFFC, 1, 1'b0, 1'b0, 16'hFFFC};
        rows[3] = '{16'h0101, 2, 1'b0, 1'b1, 16'h0100};
        rows[4] = '{16'h0200, 1, 1'b1, 1'b1, 16'h0200};

        #1 rst = 1'b0;
        #1 check_reset_vals();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;

        // Straight-line fetch at latency 1.
        cycle();
        chk("boot_req", req_s, 1);
        chk("boot_addr", addr_s, 16'h0000);
        for (int k = 0; k < 10 && !Valid_PC; k++) cycle();
        chk("first_valid_cycle", cyc, 3);

        // Stall while 0x0004 is presented.
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (Valid_PC && PC_plus2 == 16'h0006) found = 1;
            else cycle();
        end
        chk("reach_addr4", found, 1);
        Stall = 1'b1;
        repeat (3) cycle();
        Stall = 1'b0;
        cycle();
        chk("post_stall_valid", Valid_PC, 1);
        chk("post_stall_pcp2", PC_plus2, 16'h0008);

        // Redirect table.
        for (int i = 0; i < 5; i++) begin
            lat = rows[i].lat;
            repeat (5) cycle();
            Stall          = rows[i].stall;
            Redirect_valid = 1'b1;
            Redirect_pc    = rows[i].target;
            cycle();
            Redirect_valid = 1'b0;
            Stall          = 1'b0;
            chk("redir_err", err, rows[i].exp_err);
            first_req(rows[i].first);
            repeat (12) cycle();
        end

        // Random ready and stall.
        lat        = 2;
        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            Stall = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rand_ready = 0;
        Stall      = 1'b0;
        repeat (8) cycle();

        // Halt once 0x000A is presented.
        lat            = 1;
        Redirect_valid = 1'b1;
        Redirect_pc    = 16'h0000;
        cycle();
        Redirect_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (Valid_PC && PC_plus2 == 16'h000C) found = 1;
            else cycle();
        end
        chk("reach_addrA", found, 1);
        Halt   = 1'b1;
        halted = 1;
        repeat (10) cycle();
        chk("halt_drained", exp_q.size(), 0);
        Redirect_valid = 1'b1;
        Redirect_pc    = 16'h0300;
        cycle();
        Redirect_valid = 1'b0;
        repeat (8) cycle();
        chk("halt_redir_valid", Valid_PC, 0);

        // Only reset restarts fetch.
        reset_dut(0);
        first_req(16'h0000);
        repeat (20) cycle();
        chk("err_cleared", err, 0);

        // Async reset mid-flight with a response pulse.
        lat = 3;
        repeat (6) cycle();
        reset_dut(1);
        lat = 1;
        first_req(16'h0000);
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
